io_sequencer: RTL and testbench
===============================

IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 BASE_ADDR, 32'h0000_0000, byte address of first data-memory word loaded and dumped.
REQ-002 LOAD_WORDS, 16, words written before run; legal 1..255.
REQ-003 DUMP_WORDS, 16, words read back after halt; legal 1..255.
REQ-004 TIMEOUT, 4096, maximum RUN cycles before error; legal 2..65535.
REQ-005 CLK  input  1  rising-edge clock shared with the CPU.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 Go  input  1  session-start request, sampled each cycle.
REQ-008 HostValid  input  1  load word available.
REQ-009 HostData  input  32  load word.
REQ-010 HostReady  output  1  sequencer accepts HostData this cycle.
REQ-011 Start  output  1  drives CPU Start (CPU runs while 1).
REQ-012 Stop  output  1  drives CPU Stop (external memory write strobe).
REQ-013 Verify  output  1  drives CPU Verify (external memory read strobe).
REQ-014 AddrToCpu  output  32  drives CPU AddfromExtern.
REQ-015 NumToCpu  output  32  drives CPU NumfromExtern.
REQ-016 Halt  input  1  CPU Halt.
REQ-017 NumFromCpu  input  32  CPU NumtoExtern (combinational memory read data).
REQ-018 DumpValid  output  1  dump word valid.
REQ-019 DumpData  output  32  dump word.
REQ-020 DumpReady  input  1  consumer accepts dump word.
REQ-021 Busy, Done, TimeoutErr  output  1 each  session status.
REQ-022 RunCycles  output  16  cycles spent in RUN.

Function
REQ-023 The block SHALL be a Moore FSM with states IDLE, LOAD, WRITE, RUN, DUMP_RD, DUMP_OUT, DONE, ERR; all outputs registered.
REQ-024 IDLE/DONE/ERR: Go=1 -> LOAD, clear idx, RunCycles, Done, TimeoutErr; Go ignored in other states.
REQ-025 LOAD: HostReady=1; on HostValid&HostReady capture HostData into NumToCpu, AddrToCpu=BASE_ADDR+4*idx -> WRITE; HostValid=0 stays in LOAD.
REQ-026 WRITE: Stop=1 for exactly one cycle, HostReady=0, address/data stable; then idx==LOAD_WORDS-1 -> RUN (idx cleared), else idx++ -> LOAD.
REQ-027 RUN: Start=1 continuously, Stop=Verify=0; RunCycles increments each cycle, saturating at 16'hFFFF.
REQ-028 RUN: Halt ignored in first RUN cycle; Halt=1 thereafter -> DUMP_RD with Start=0 next cycle.
REQ-029 RUN: RunCycles reaching TIMEOUT with no Halt -> ERR; Halt and timeout in same cycle -> Halt wins.
REQ-030 DUMP_RD: Verify=1 one cycle, AddrToCpu=BASE_ADDR+4*idx; NumFromCpu captured into DumpData at end of cycle -> DUMP_OUT.
REQ-031 DUMP_OUT: DumpValid=1, DumpData stable until DumpReady=1; on handshake idx==DUMP_WORDS-1 -> DONE else idx++ -> DUMP_RD.
REQ-032 DONE: Done=1; ERR: TimeoutErr=1, Start=0; both held until Go.
REQ-033 Start, Stop, Verify SHALL be mutually exclusive every cycle.
REQ-034 Address arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-035 Busy=1 in LOAD, WRITE, RUN, DUMP_RD, DUMP_OUT; 0 otherwise.

Reset
REQ-036 Reset_n=0 SHALL asynchronously force IDLE, all outputs 0, idx and RunCycles 0.
REQ-037 Reset mid-RUN SHALL drop Start without waiting for CLK; reset mid-WRITE/DUMP SHALL abandon the word with no further strobe.

Structure
REQ-038 State encodings, ADDR_STEP=4 and counter widths SHALL live in shared header io_seq_defs.vh.
REQ-039 One sub-module, run_timer (saturating 16-bit counter, terminal-count flag vs TIMEOUT), SHALL implement REQ-027/029.

Verification
REQ-040 LOAD_WORDS=2, host sends 32'h11,32'h22 -> Stop pulses with (Addr,Num)=(0,11),(4,22), one cycle each.
REQ-041 Halt raised at RUN cycle 10 -> Start falls next cycle, RunCycles=10, first Verify Addr=0.
REQ-042 DUMP_WORDS=3, NumFromCpu=A,B,C, DumpReady low 5 cycles on word 2 -> DumpData=B stable, no extra Verify, Done=1 after C.
REQ-043 TIMEOUT=8, Halt never -> ERR after 8 RUN cycles, TimeoutErr=1, Start=0; Go -> LOAD, TimeoutErr=0.
REQ-044 Reset_n=0 mid-RUN -> Start=0 before next CLK edge, state IDLE; Go during RUN -> ignored.
REQ-045 BASE_ADDR=32'hFFFF_FFFC, LOAD_WORDS=2 -> write addresses FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/io_sequencer_pkg.sv
// Shared definitions for the io_sequencer session controller: state encoding,
// address stride and counter widths.
package io_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int ADDR_STEP = 4;
    localparam int IDX_W     = 8;
    localparam int CNT_W     = 16;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [IDX_W-1:0] idx);
        return base + 32'(ADDR_STEP) * 32'(idx);
    endfunction

endpackage

// File: rtl/io_sequencer_run_timer.sv
// Saturating RUN-cycle counter with a terminal-count flag that fires on the
// cycle whose increment reaches TIMEOUT.
module run_timer
    import io_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/io_sequencer.sv
// Session sequencer: loads words into CPU memory, runs the CPU until Halt or
// timeout, then dumps memory words to a consumer. Moore FSM, registered outputs.
module io_sequencer
    import io_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LOAD_WORDS = 16,
    parameter int          DUMP_WORDS = 16,
    parameter int          TIMEOUT    = 4096
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Go,
    input  logic        HostValid,
    input  logic [31:0] HostData,
    output logic        HostReady,
    output logic        Start,
    output logic        Stop,
    output logic        Verify,
    output logic [31:0] AddrToCpu,
    output logic [31:0] NumToCpu,
    input  logic        Halt,
    input  logic [31:0] NumFromCpu,
    output logic        DumpValid,
    output logic [31:0] DumpData,
    input  logic        DumpReady,
    output logic        Busy,
    output logic        Done,
    output logic        TimeoutErr,
    output logic [15:0] RunCycles
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [31:0]      addr_nxt, num_nxt, dump_nxt;
    logic             run_clr, run_tc, first_run;

    run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (CLK),
        .rst_n (Reset_n),
        .clr   (run_clr),
        .en    (state == S_RUN),
        .count (RunCycles),
        .tc    (run_tc)
    );

    // Counter is cleared on Go, so zero marks the first RUN cycle.
    assign first_run = (RunCycles == '0);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        run_clr   = 1'b0;
        num_nxt   = NumToCpu;
        dump_nxt  = DumpData;
        addr_nxt  = AddrToCpu;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (Go) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                    run_clr   = 1'b1;
                end
            end
            S_LOAD: begin
                if (HostValid && HostReady) begin
                    state_nxt = S_WRITE;
                    num_nxt   = HostData;
                end
            end
            S_WRITE: begin
                if (idx == IDX_W'(LOAD_WORDS - 1)) begin
                    state_nxt = S_RUN;
                    idx_nxt   = '0;
                end else begin
                    state_nxt = S_LOAD;
                    idx_nxt   = idx + 1'b1;
                end
            end
            S_RUN: begin
                if (Halt && !first_run) state_nxt = S_DUMP_RD;
                else if (run_tc)        state_nxt = S_ERR;
            end
            S_DUMP_RD: begin
                state_nxt = S_DUMP_OUT;
                dump_nxt  = NumFromCpu;
            end
            S_DUMP_OUT: begin
                if (DumpReady) begin
                    if (idx == IDX_W'(DUMP_WORDS - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DUMP_RD;
                        idx_nxt   = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt == S_WRITE || state_nxt == S_DUMP_RD)
            addr_nxt = word_addr(BASE_ADDR, idx_nxt);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            AddrToCpu  <= '0;
            NumToCpu   <= '0;
            DumpData   <= '0;
            HostReady  <= 1'b0;
            Start      <= 1'b0;
            Stop       <= 1'b0;
            Verify     <= 1'b0;
            DumpValid  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            TimeoutErr <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            AddrToCpu  <= addr_nxt;
            NumToCpu   <= num_nxt;
            DumpData   <= dump_nxt;
            // Strobes decode the next state so they line up with the state register.
            HostReady  <= (state_nxt == S_LOAD);
            Start      <= (state_nxt == S_RUN);
            Stop       <= (state_nxt == S_WRITE);
            Verify     <= (state_nxt == S_DUMP_RD);
            DumpValid  <= (state_nxt == S_DUMP_OUT);
            Busy       <= (state_nxt inside {S_LOAD, S_WRITE, S_RUN, S_DUMP_RD, S_DUMP_OUT});
            Done       <= (state_nxt == S_DONE);
            TimeoutErr <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_io_sequencer.sv
// Scoreboard bench for io_sequencer: two instances (base 0 / base FFFF_FFFC)
// exercise load, halt, dump back-pressure, timeout, reset and address wrap.
module tb_io_sequencer;

    typedef enum logic [1:0] {EV_WR, EV_RD, EV_DUMP} ev_kind_t;
    typedef struct {
        int          dut;
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;

    logic        CLK = 1'b0;
    logic        rst[2];
    logic        go[2], hv[2], hr[2], st[2], sp[2], vf[2], hlt[2];
    logic        dv[2], dr[2], bsy[2], dn[2], te[2];
    logic [31:0] hd[2], ad[2], nm[2], nfc[2], dd[2];
    logic [15:0] rc[2];

    int  tests = 0;
    int  fails = 0;
    int  excl  = 0;
    ev_t q[$];

    always #5 CLK = ~CLK;

    io_sequencer #(.BASE_ADDR(32'h0000_0000), .LOAD_WORDS(2), .DUMP_WORDS(3), .TIMEOUT(20)) dut0 (
        .CLK(CLK), .Reset_n(rst[0]), .Go(go[0]), .HostValid(hv[0]), .HostData(hd[0]),
        .HostReady(hr[0]), .Start(st[0]), .Stop(sp[0]), .Verify(vf[0]), .AddrToCpu(ad[0]),
        .NumToCpu(nm[0]), .Halt(hlt[0]), .NumFromCpu(nfc[0]), .DumpValid(dv[0]),
        .DumpData(dd[0]), .DumpReady(dr[0]), .Busy(bsy[0]), .Done(dn[0]),
        .TimeoutErr(te[0]), .RunCycles(rc[0]));

    io_sequencer #(.BASE_ADDR(32'hFFFF_FFFC), .LOAD_WORDS(2), .DUMP_WORDS(1), .TIMEOUT(8)) dut1 (
        .CLK(CLK), .Reset_n(rst[1]), .Go(go[1]), .HostValid(hv[1]), .HostData(hd[1]),
        .HostReady(hr[1]), .Start(st[1]), .Stop(sp[1]), .Verify(vf[1]), .AddrToCpu(ad[1]),
        .NumToCpu(nm[1]), .Halt(hlt[1]), .NumFromCpu(nfc[1]), .DumpValid(dv[1]),
        .DumpData(dd[1]), .DumpReady(dr[1]), .Busy(bsy[1]), .Done(dn[1]),
        .TimeoutErr(te[1]), .RunCycles(rc[1]));

    // CPU memory read models
    always_comb begin
        case (ad[0])
            32'h0: nfc[0] = WA;
            32'h4: nfc[0] = WB;
            32'h8: nfc[0] = WC;
            default: nfc[0] = 32'hDEAD_BEEF;
        endcase
    end
    assign nfc[1] = ad[1] ^ 32'h5A5A_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input ev_kind_t k, input logic [31:0] a, input logic [31:0] v);
        ev_t e;
        e.dut = d; e.kind = k; e.addr = a; e.data = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go_pulse(input int d);
        go[d] = 1'b1;
        tick();
        go[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [31:0] w);
        logic hs;
        bit   ok = 1'b0;
        hv[d] = 1'b1;
        hd[d] = w;
        for (int n = 0; n < 50; n++) begin
            hs = hr[d];
            tick();
            if (hs) begin ok = 1'b1; break; end
        end
        hv[d] = 1'b0;
        if (!ok) check("host_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_start(input int d);
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (st[d]) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("start_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_dv(input int d);
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (dv[d]) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("dump_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input int d);
        dr[d] = 1'b1;
        tick();
        dr[d] = 1'b0;
    endtask

    // Monitor: every strobe/handshake consumes one scoreboard entry
    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (int'(st[d]) + int'(sp[d]) + int'(vf[d]) > 1) excl++;
            if (sp[d] === 1'b1 || vf[d] === 1'b1 || (dv[d] === 1'b1 && dr[d] === 1'b1)) begin
                ev_kind_t k;
                k = sp[d] ? EV_WR : (vf[d] ? EV_RD : EV_DUMP);
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_event dut%0d kind=%0d addr=%h", d, k, ad[d]);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("event_dut", 32'(d), 32'(e.dut));
                    check("event_kind", 32'(k), 32'(e.kind));
                    if (k == EV_WR) begin
                        check("write_addr", ad[d], e.addr);
                        check("write_data", nm[d], e.data);
                    end else if (k == EV_RD) begin
                        check("verify_addr", ad[d], e.addr);
                    end else begin
                        check("dump_data", dd[d], e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; go[d] = 1'b0; hv[d] = 1'b0; hd[d] = '0; hlt[d] = 1'b0; dr[d] = 1'b0;
        end
        #13;
        check("rst_start0", 32'(st[0]), 32'd0);
        check("rst_busy0", 32'(bsy[0]), 32'd0);
        check("rst_hostready0", 32'(hr[0]), 32'd0);
        check("rst_runcycles0", 32'(rc[0]), 32'd0);
        check("rst_addr1", ad[1], 32'd0);
        check("rst_done1", 32'(dn[1]), 32'd0);
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick();
        check("idle_busy0", 32'(bsy[0]), 32'd0);

        // dut0: load two words, halt at RUN cycle 10, dump three words
        go_pulse(0);
        check("load_hostready", 32'(hr[0]), 32'd1);
        check("load_busy", 32'(bsy[0]), 32'd1);
        push(0, EV_WR, 32'h0, 32'h11);
        push(0, EV_WR, 32'h4, 32'h22);
        send(0, 32'h11);
        send(0, 32'h22);
        wait_start(0);
        for (int k = 2; k <= 10; k++) begin
            tick();
            if (k == 3) go[0] = 1'b1;
            if (k == 4) go[0] = 1'b0;
        end
        check("go_ignored_start", 32'(st[0]), 32'd1);
        check("run_runcycles9", 32'(rc[0]), 32'd9);
        push(0, EV_RD, 32'h0, 32'h0);
        push(0, EV_DUMP, 32'h0, WA);
        push(0, EV_RD, 32'h4, 32'h0);
        push(0, EV_DUMP, 32'h4, WB);
        push(0, EV_RD, 32'h8, 32'h0);
        push(0, EV_DUMP, 32'h8, WC);
        hlt[0] = 1'b1;
        tick();
        hlt[0] = 1'b0;
        check("halt_start_low", 32'(st[0]), 32'd0);
        check("halt_runcycles", 32'(rc[0]), 32'd10);
        for (int w = 0; w < 3; w++) begin
            wait_dv(0);
            if (w == 1) begin
                for (int c = 0; c < 5; c++) begin
                    check("stall_data_stable", dd[0], WB);
                    check("stall_no_verify", 32'(vf[0]), 32'd0);
                    check("stall_valid", 32'(dv[0]), 32'd1);
                    tick();
                end
            end
            accept(0);
        end
        check("done_flag", 32'(dn[0]), 32'd1);
        check("done_busy", 32'(bsy[0]), 32'd0);
        check("done_runcycles", 32'(rc[0]), 32'd10);

        // dut0: reset mid-RUN
        go_pulse(0);
        check("rego_done_clr", 32'(dn[0]), 32'd0);
        push(0, EV_WR, 32'h0, 32'h33);
        push(0, EV_WR, 32'h4, 32'h44);
        send(0, 32'h33);
        send(0, 32'h44);
        wait_start(0);
        tick(); tick();
        rst[0] = 1'b0;
        #2;
        check("async_rst_start", 32'(st[0]), 32'd0);
        check("async_rst_busy", 32'(bsy[0]), 32'd0);
        check("async_rst_runcycles", 32'(rc[0]), 32'd0);
        rst[0] = 1'b1;
        tick();
        check("after_rst_idle", 32'(bsy[0]), 32'd0);
        check("after_rst_start", 32'(st[0]), 32'd0);

        // dut1: wrapping addresses, timeout after 8 RUN cycles
        go_pulse(1);
        push(1, EV_WR, 32'hFFFF_FFFC, 32'h5);
        push(1, EV_WR, 32'h0000_0000, 32'h6);
        send(1, 32'h5);
        send(1, 32'h6);
        wait_start(1);
        begin
            int n = 0;
            while (st[1] && n < 30) begin
                n++;
                tick();
            end
            check("timeout_run_len", 32'(n), 32'd8);
        end
        check("timeout_err", 32'(te[1]), 32'd1);
        check("timeout_runcycles", 32'(rc[1]), 32'd8);
        check("timeout_start", 32'(st[1]), 32'd0);
        check("timeout_busy", 32'(bsy[1]), 32'd0);
        go_pulse(1);
        check("err_go_clr", 32'(te[1]), 32'd0);
        check("err_go_load", 32'(hr[1]), 32'd1);
        check("err_go_runcycles", 32'(rc[1]), 32'd0);

        // dut1: Halt held from the first RUN cycle is honoured only on the second
        push(1, EV_WR, 32'hFFFF_FFFC, 32'h7);
        push(1, EV_WR, 32'h0000_0000, 32'h8);
        send(1, 32'h7);
        send(1, 32'h8);
        hlt[1] = 1'b1;
        wait_start(1);
        push(1, EV_RD, 32'hFFFF_FFFC, 32'h0);
        push(1, EV_DUMP, 32'hFFFF_FFFC, 32'hA5A5_FFFC);
        tick();
        check("halt_first_ignored", 32'(st[1]), 32'd1);
        tick();
        hlt[1] = 1'b0;
        check("halt2_start_low", 32'(st[1]), 32'd0);
        check("halt2_runcycles", 32'(rc[1]), 32'd2);
        wait_dv(1);
        accept(1);
        check("done1_flag", 32'(dn[1]), 32'd1);

        tick(); tick();
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        check("strobe_exclusive", 32'(excl), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
